serial_cfg_tx: RTL

// - Host-side serial configuration transmitter. Serialises a DATA_W-bit config word onto o_sclk/o_sdin
//   to feed the backend's i_sclk/i_sdin inputs.
// - Sits in the FPGA test controller, driven by host config logic through a valid/ready handshake.
// - Sends bits LSB-first. o_sdin changes only while o_sclk is low; the receiver samples on the o_sclk rising edge.

---
 rtl/serial_cfg_tx_if.sv | 27 ++
 rtl/serial_cfg_tx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_cfg_tx_if.sv
// Host-side handshake bundle for serial_cfg_tx: config word in, status back.
// Signal names are from the transmitter's point of view.
interface serial_cfg_tx_if #(
    parameter int DATA_W = 5
);
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/serial_cfg_tx.sv
// Serial configuration transmitter: shifts a config word LSB-first onto o_sclk/o_sdin.
// Optional trailing even-parity bit when SERIAL_CFG_TX_PARITY_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready for a new word, sclk low
// S_SETUP | sclk low, current bit held on sdin ahead of the rising edge
// S_HIGH  | sclk high, receiver sampling the current bit
// S_STOP  | trailing sclk-low gap before o_done
module serial_cfg_tx #(
    parameter int DATA_W  = 5,
    parameter int CLK_DIV = 4,
    parameter int GAP     = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    serial_cfg_tx_if.slave   cfg,
    output logic             o_sclk,
    output logic             o_sdin
);

`ifdef SERIAL_CFG_TX_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(NBITS + 1);
    localparam int GAP_W = $clog2(GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_STOP
    } state_t;

    state_t             r_state,  w_state;
    logic [NBITS-1:0]   r_shift,  w_shift;
    logic [DIV_W-1:0]   r_div,    w_div;
    logic [BIT_W-1:0]   r_bit,    w_bit;
    logic [GAP_W-1:0]   r_gap,    w_gap;
    logic               r_sclk,   w_sclk;
    logic               r_sdin,   w_sdin;
    logic               r_busy,   w_busy;
    logic               r_done,   w_done;
    logic [NBITS-1:0]   w_frame;
    logic [NBITS-1:0]   w_shift_nx;

`ifdef SERIAL_CFG_TX_PARITY_EN
    assign w_frame = {^cfg.i_data, cfg.i_data};
`else
    assign w_frame = cfg.i_data;
`endif
    assign w_shift_nx = r_shift >> 1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_sclk  <= 1'b0;
            r_sdin  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_shift <= w_shift;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_gap   <= w_gap;
            r_sclk  <= w_sclk;
            r_sdin  <= w_sdin;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state = r_state;
        w_shift = r_shift;
        w_div   = r_div;
        w_bit   = r_bit;
        w_gap   = r_gap;
        w_sclk  = r_sclk;
        w_sdin  = r_sdin;
        w_busy  = r_busy;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg.i_valid) begin
                    // First setup phase is CLK_DIV+1 cycles long: the accept cycle plus CLK_DIV.
                    w_shift = w_frame;
                    w_sdin  = w_frame[0];
                    w_busy  = 1'b1;
                    w_div   = DIV_W'(CLK_DIV);
                    w_bit   = BIT_W'(NBITS - 1);
                    w_state = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_div == '0) begin
                    w_sclk  = 1'b1;
                    w_div   = DIV_W'(CLK_DIV - 1);
                    w_state = S_HIGH;
                end else begin
                    w_div = r_div - DIV_W'(1);
                end
            end
            S_HIGH: begin
                if (r_div == '0) begin
                    w_sclk = 1'b0;
                    if (r_bit != '0) begin
                        w_shift = w_shift_nx;
                        w_sdin  = w_shift_nx[0];
                        w_bit   = r_bit - BIT_W'(1);
                        w_div   = DIV_W'(CLK_DIV - 1);
                        w_state = S_SETUP;
                    end else begin
                        w_sdin = 1'b0;
                        // The falling-edge cycle already counts as the first gap cycle.
                        if (GAP == 1) begin
                            w_done  = 1'b1;
                            w_busy  = 1'b0;
                            w_state = S_IDLE;
                        end else begin
                            w_gap   = GAP_W'(GAP - 2);
                            w_state = S_STOP;
                        end
                    end
                end else begin
                    w_div = r_div - DIV_W'(1);
                end
            end
            S_STOP: begin
                if (r_gap == '0) begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    w_gap = r_gap - GAP_W'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign cfg.o_ready = (r_state == S_IDLE);
    assign cfg.o_busy  = r_busy;
    assign cfg.o_done  = r_done;
    assign o_sclk      = r_sclk;
    assign o_sdin      = r_sdin;

endmodule
